load_unit: RTL
==============

# load_unit

Sequential MIPS load unit between the decode/execute stage and the Harvard data memory. It accepts one load per transaction and issues a word-aligned read with a wait-request handshake. It then extracts, extends or merges the returned word for all seven MIPS loads (LB, LBU, LH, LHU, LW, LWL, LWR) and returns the register write-back value with a done pulse. It generalises the earlier combinational LWL/LWR merge with sub-word loads, a stalling memory interface, a timeout and error reporting.

## Interface
- ADDR_WIDTH, 32: byte-address width.
- TIMEOUT_CYCLES, 16: consecutive wait-request cycles before the transaction aborts; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted when busy=0
- opcode  in  6  instruction[31:26]
- address  in  ADDR_WIDTH  effective byte address
- reg_rt  in  32  current rt value, used by LWL/LWR
- mem_address  out  ADDR_WIDTH  {address[ADDR_WIDTH-1:2],2'b00}
- mem_read  out  1  read request
- mem_waitrequest  in  1  high means memory not ready
- mem_readdata  in  32  valid in any cycle with mem_read=1 and mem_waitrequest=0
- busy  out  1  transaction in flight
- done  out  1  one-cycle completion pulse
- result  out  32  write-back value, held until the next accepted start
- error  out  1  qualifies done: illegal opcode, timeout or misaligned access

## Operation
- Byte lanes are big-endian. Offset k=address[1:0] selects mem_readdata[31-8k -: 8]. Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- LB (100000) sign-extends the byte. LBU (100100) zero-extends it.
- LH (100001) sign-extends the halfword. LHU (100101) zero-extends it. Both use address[1] to select the halfword.
- LW (100011) returns the whole word.
- LWL (100010) by offset:
  - 0: word
  - 1: {rd[23:0],rt[7:0]}
  - 2: {rd[15:0],rt[15:0]}
  - 3: {rd[7:0],rt[23:0]}
- LWR (100110) by offset:
  - 0: {rt[31:8],rd[31:24]}
  - 1: {rt[31:16],rd[31:16]}
  - 2: {rt[31:24],rd[31:8]}
  - 3: word
- FSM states are IDLE, REQ and DONE.
  - IDLE/DONE with start=1 and a legal opcode: capture opcode, address and reg_rt, clear the timeout counter, go to REQ.
  - IDLE/DONE with start=1 and an illegal opcode: go to DONE with error=1 and result=0. No memory access.
  - REQ with mem_waitrequest=0: latch the merged result and go to DONE with error=0.
  - REQ with mem_waitrequest=1: increment the counter. When the counter reaches TIMEOUT_CYCLES, go to DONE with error=1 and result=0, and drop mem_read.
  - DONE with no start: go to IDLE.
- start while busy=1 is ignored. Inputs other than mem_* are not sampled after acceptance.

## Timing
- Reset values: state IDLE; mem_read, busy, done and error are 0; result is 0; mem_address is 0.
- mem_read=1 and busy=1 exactly while in REQ. mem_address is stable throughout REQ.
- Latency: start accepted at edge N. REQ occupies cycle N+1. With zero wait, done=1 in cycle N+2. Each wait cycle adds 1.
- done and error are high for exactly one cycle, in DONE. busy=0 in DONE, so a start in the same cycle is accepted back-to-back, giving one transaction per 2 cycles.
- Timeout: done occurs in the cycle after the TIMEOUT_CYCLES-th consecutive wait cycle.
- Reset asserted mid-transaction: state returns to IDLE at that edge and mem_read drops in the following cycle. The aborted load produces no done.

## Configuration
- LOAD_UNIT_MISALIGN_TRAP_EN defined: LH/LHU with address[0]=1, or LW with address[1:0]≠0, goes straight to DONE with error=1 and result=0. No memory access.
- Macro undefined: LH/LHU ignore address[0] and LW ignores address[1:0]. No trap is raised.
- LB/LBU/LWL/LWR are never misaligned.

## Structure
- Package load_unit_pkg holds:
  - the seven opcode localparams;
  - the state enum {IDLE,REQ,DONE};
  - an is_legal_load() function.
- One combinational sub-module, load_merge, takes opcode, offset, mem_readdata and reg_rt and produces the extended or merged word. The FSM, timeout counter and capture registers stay in load_unit.

## Test plan
- LB at address 0x101 with readdata 0x12F45678 and zero wait → done in cycle N+2, result 0xFFFFFFF4, error=0.
- LHU at address 0x102 with readdata 0xAAAA8001 and 3 wait cycles → mem_read high for 4 cycles, mem_address 0x100, result 0x00008001.
- LWL at offset 2 and LWR at offset 1, with rt=0x11223344 and readdata 0xAABBCCDD → results 0xCCDD3344 and 0x1122AABB respectively.
- mem_waitrequest stuck high with TIMEOUT_CYCLES=4 → done with error=1 and result 0 in cycle N+5; then a back-to-back start in the DONE cycle is accepted.
- Opcode 0x00 → done and error in cycle N+1 with no mem_read. LW at 0x102 → error with the macro defined; the aligned word is returned without it.
- Reset asserted in the second REQ cycle → busy and mem_read are 0 after reset releases and no done pulse occurs. start during busy → ignored.

Source files
------------

// File: rtl/load_unit_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the MIPS load unit.
package load_unit_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LWL = 6'b100010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LWR = 6'b100110;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

   function automatic logic is_legal_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

   // LB/LBU/LWL/LWR are byte-granular and can never be misaligned.
   function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] offset);
      case (op)
         OP_LH, OP_LHU: return offset[0];
         OP_LW:         return offset != 2'b00;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_merge.sv
// Combinational lane extraction, sign/zero extension and LWL/LWR merge of a
// big-endian memory word with the current rt value.
module load_merge
   import load_unit_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rd_i,
   input  logic [31:0] rt_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      byte_v   = rd_i[31:24];
      half_v   = offset_i[1] ? rd_i[15:0] : rd_i[31:16];
      result_o = '0;

      case (offset_i)
         2'd0:    byte_v = rd_i[31:24];
         2'd1:    byte_v = rd_i[23:16];
         2'd2:    byte_v = rd_i[15:8];
         default: byte_v = rd_i[7:0];
      endcase

      case (opcode_i)
         OP_LB:  result_o = {{24{byte_v[7]}}, byte_v};
         OP_LBU: result_o = {24'h0, byte_v};
         OP_LH:  result_o = {{16{half_v[15]}}, half_v};
         OP_LHU: result_o = {16'h0, half_v};
         OP_LW:  result_o = rd_i;
         OP_LWL: begin
            case (offset_i)
               2'd0:    result_o = rd_i;
               2'd1:    result_o = {rd_i[23:0], rt_i[7:0]};
               2'd2:    result_o = {rd_i[15:0], rt_i[15:0]};
               default: result_o = {rd_i[7:0], rt_i[23:0]};
            endcase
         end
         OP_LWR: begin
            case (offset_i)
               2'd0:    result_o = {rt_i[31:8], rd_i[31:24]};
               2'd1:    result_o = {rt_i[31:16], rd_i[31:16]};
               2'd2:    result_o = {rt_i[31:24], rd_i[31:8]};
               default: result_o = rd_i;
            endcase
         end
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Sequential MIPS load unit: one word-aligned read per load, wait-request
// handshake with timeout. Define LOAD_UNIT_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW.
module load_unit
   import load_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [5:0]            opcode,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           reg_rt,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   input  logic                  mem_waitrequest,
   input  logic [31:0]           mem_readdata,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           result,
   output logic                  error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_e                  state_q;
   logic [5:0]              op_q;
   logic [1:0]              off_q;
   logic [31:0]             rt_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   mem_address_q;
   logic                    mem_read_q, busy_q, done_q, error_q;
   logic [31:0]             result_q, result_d;
   logic                    reject;

   assign cnt_d = cnt_q + CNT_W'(1);

`ifdef LOAD_UNIT_MISALIGN_TRAP_EN
   assign reject = !is_legal_load(opcode) || is_misaligned(opcode, address[1:0]);
`else
   assign reject = !is_legal_load(opcode);
`endif

   load_merge u_merge (
      .opcode_i (op_q),
      .offset_i (off_q),
      .rd_i     (mem_readdata),
      .rt_i     (rt_q),
      .result_o (result_d)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= '0;
         off_q         <= '0;
         rt_q          <= '0;
         cnt_q         <= '0;
         mem_address_q <= '0;
         mem_read_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         result_q      <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (!start) begin
                  state_q <= IDLE;
               end else if (reject) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  error_q  <= 1'b1;
                  result_q <= '0;
               end else begin
                  state_q       <= REQ;
                  op_q          <= opcode;
                  off_q         <= address[1:0];
                  rt_q          <= reg_rt;
                  cnt_q         <= '0;
                  mem_address_q <= {address[ADDR_WIDTH-1:2], 2'b00};
                  mem_read_q    <= 1'b1;
                  busy_q        <= 1'b1;
               end
            end
            REQ: begin
               if (!mem_waitrequest) begin
                  state_q    <= DONE;
                  result_q   <= result_d;
                  done_q     <= 1'b1;
                  mem_read_q <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (cnt_d == TIMEOUT_LIM) begin
                  state_q    <= DONE;
                  result_q   <= '0;
                  done_q     <= 1'b1;
                  error_q    <= 1'b1;
                  mem_read_q <= 1'b0;
                  busy_q     <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_address = mem_address_q;
   assign mem_read    = mem_read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign result      = result_q;

endmodule
